// File: rtl/pwm_duty_decoder.sv
// Receive-side PWM decoder: measures high time and period of each cycle on a
// synchronized PWM line, flags stalled lines and a broken complementary pair.
module pwm_duty_decoder #(
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   input  logic             neg_pwm_in,
   output logic [CNT_W-1:0] duty_out,
   output logic [CNT_W-1:0] period_out,
   output logic             valid,
   output logic             stall,
   output logic             level,
   output logic             pair_err
);

   localparam logic [CNT_W-1:0] MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_STALL
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_p;
   logic [SYNC_STAGES-1:0] sync_n;
   logic [SYNC_STAGES-1:0] primed;
   logic                   s;
   logic                   n;
   logic                   s_d;
   logic                   rise;
   logic                   mismatch;
   logic                   mismatch_d;
   logic [CNT_W-1:0]       period_cnt;
   logic [CNT_W-1:0]       high_cnt;
   logic                   period_sat;

   assign s          = sync_p[SYNC_STAGES-1];
   assign n          = sync_n[SYNC_STAGES-1];
   assign rise       = s & ~s_d;
   assign period_sat = (period_cnt == MAX);

   // The chains clear to 0 on reset, so s == n right after release; the pair
   // check waits until both chains hold real post-reset samples.
   assign mismatch   = primed[SYNC_STAGES-1] & (s == n);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p     <= '0;
         sync_n     <= '0;
         primed     <= '0;
         s_d        <= 1'b0;
         mismatch_d <= 1'b0;
         pair_err   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // in the chain samples the previous-cycle value of its neighbour.
         sync_p     <= {sync_p[SYNC_STAGES-2:0], pwm_in};
         sync_n     <= {sync_n[SYNC_STAGES-2:0], neg_pwm_in};
         primed     <= {primed[SYNC_STAGES-2:0], 1'b1};
         s_d        <= s;
         mismatch_d <= mismatch;
         if (mismatch && mismatch_d)
            pair_err <= 1'b1;
      end
   end

   // Both counters saturate at MAX; high_cnt can never pass period_cnt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_cnt <= '0;
         high_cnt   <= '0;
      end else if (rise) begin
         period_cnt <= CNT_W'(1);
         high_cnt   <= CNT_W'(1);
      end else begin
         if (!period_sat)
            period_cnt <= period_cnt + CNT_W'(1);
         if (s && (high_cnt != MAX))
            high_cnt <= high_cnt + CNT_W'(1);
      end
   end

   // A rise always takes priority over saturation in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         duty_out   <= '0;
         period_out <= '0;
         valid      <= 1'b0;
         stall      <= 1'b0;
         level      <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (rise) begin
            if (state == ST_ARMED) begin
               duty_out   <= high_cnt;
               period_out <= period_cnt;
               valid      <= 1'b1;
            end
            state <= ST_ARMED;
            stall <= 1'b0;
            level <= 1'b0;
         end else if (state == ST_STALL) begin
            level <= s;
         end else if (period_sat) begin
            state      <= ST_STALL;
            stall      <= 1'b1;
            level      <= s;
            duty_out   <= s ? MAX : '0;
            period_out <= '0;
            valid      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: table-driven PWM patterns plus
// hand-written stall, pair-check and mid-cycle reset sequences.
module tb_pwm_duty_decoder;

   logic       clk;
   logic       reset;
   logic       pwm_in;
   logic       neg_pwm_in;
   logic [7:0] duty_out;
   logic [7:0] period_out;
   logic       valid;
   logic       stall;
   logic       level;
   logic       pair_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int period;
      int high;
      int exp_duty;
      int exp_period;
   } vec_t;

   vec_t vecs[5];

   pwm_duty_decoder #(.CNT_W(8), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .pwm_in     (pwm_in),
      .neg_pwm_in (neg_pwm_in),
      .duty_out   (duty_out),
      .period_out (period_out),
      .valid      (valid),
      .stall      (stall),
      .level      (level),
      .pair_err   (pair_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic p, input logic nv);
      pwm_in     = p;
      neg_pwm_in = nv;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b1);
      repeat (2) tick();
      reset = 1'b0;
   endtask

   logic p;
   logic prev;
   int   nvalid;
   int   first_idx;
   int   seen;

   initial begin
      vecs[0] = '{10, 3, 3, 10};
      vecs[1] = '{20, 15, 15, 20};
      vecs[2] = '{2, 1, 1, 2};
      vecs[3] = '{7, 6, 6, 7};
      vecs[4] = '{254, 253, 253, 254};

      // Reset held while pwm_in toggles: every output stays 0.
      reset = 1'b1;
      drive(1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         p = ((i % 2) == 1);
         drive(p, !p);
         tick();
         check("reset_outputs", {duty_out, period_out, valid, stall, level, pair_err}, 0);
      end

      // Table: after reset the rise at index 0 arms, rises at P..4P report.
      for (int k = 0; k < 5; k++) begin
         do_reset();
         nvalid    = 0;
         first_idx = -1;
         for (int i = 0; i < 5 * vecs[k].period + 2; i++) begin
            p = ((i % vecs[k].period) < vecs[k].high);
            drive(p, !p);
            tick();
            if (valid) begin
               if (first_idx < 0)
                  first_idx = i;
               nvalid++;
               check("tbl_duty", duty_out, vecs[k].exp_duty);
               check("tbl_period", period_out, vecs[k].exp_period);
            end
         end
         check("tbl_valid_count", nvalid, 4);
         check("tbl_first_valid_idx", first_idx, vecs[k].period + 2);
         check("tbl_pair_err", pair_err, 0);
         check("tbl_stall", stall, 0);
      end

      // Period 10 then held low: last rise at index 20 -> stall at index 277.
      do_reset();
      for (int i = 0; i < 30; i++) begin
         p = ((i % 10) < 3);
         drive(p, !p);
         tick();
      end
      nvalid = 0;
      for (int i = 30; i < 300; i++) begin
         drive(1'b0, 1'b1);
         tick();
         if (i == 276)
            check("low_stall_early", stall, 0);
         if (i == 277) begin
            check("low_stall", stall, 1);
            check("low_valid", valid, 1);
            check("low_duty", duty_out, 0);
            check("low_period", period_out, 0);
            check("low_level", level, 0);
         end
         if (i > 277 && valid)
            nvalid++;
      end
      check("low_no_restrobe", nvalid, 0);
      check("low_stall_held", stall, 1);

      // Held high from a rise at index 0, then period 20 / high 15 from 300.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 1'b0);
         tick();
         if (i == 256)
            check("high_stall_early", stall, 0);
         if (i == 257) begin
            check("high_stall", stall, 1);
            check("high_valid", valid, 1);
            check("high_duty", duty_out, 255);
            check("high_period", period_out, 0);
            check("high_level", level, 1);
         end
      end
      nvalid = 0;
      for (int i = 300; i < 345; i++) begin
         p = (((i - 300) % 20) < 15);
         drive(p, !p);
         tick();
         if (i == 318) begin
            check("stall_level_tracks", level, 0);
            check("stall_still_set", stall, 1);
         end
         if (i == 321)
            check("stall_before_rise", stall, 1);
         if (i == 322)
            check("stall_cleared", stall, 0);
         if (i < 342 && valid)
            nvalid++;
         if (i == 342) begin
            check("resume_valid", valid, 1);
            check("resume_duty", duty_out, 15);
            check("resume_period", period_out, 20);
         end
      end
      check("resume_no_early_valid", nvalid, 0);

      // Pair check: tied lines set pair_err within 4 cycles; it stays sticky.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         p = ((i % 10) < 3);
         drive(p, !p);
         tick();
      end
      check("pair_ok_before", pair_err, 0);
      seen = 0;
      for (int i = 20; i < 24; i++) begin
         p = ((i % 10) < 3);
         drive(p, p);
         tick();
         if (pair_err)
            seen = 1;
      end
      check("pair_err_set", seen, 1);
      for (int i = 24; i < 50; i++) begin
         p = ((i % 10) < 3);
         drive(p, !p);
         tick();
      end
      check("pair_err_sticky", pair_err, 1);

      // One-cycle skew of the complementary line is tolerated.
      do_reset();
      prev = 1'b0;
      for (int i = 0; i < 60; i++) begin
         p = ((i % 10) < 3);
         drive(p, !prev);
         prev = p;
         tick();
      end
      check("skew_tolerated", pair_err, 0);

      // Reset pulsed in the low phase of a period-10 cycle.
      do_reset();
      nvalid = 0;
      for (int i = 0; i < 50; i++) begin
         p = ((i % 10) < 3);
         drive(p, !p);
         if (i == 26) begin
            check("pre_reset_duty", duty_out, 3);
            reset = 1'b1;
            #1;
            check("async_reset_duty", duty_out, 0);
            check("async_reset_period", period_out, 0);
            check("async_reset_flags", {valid, stall, level, pair_err}, 0);
         end
         if (i == 29)
            reset = 1'b0;
         tick();
         if (i >= 29 && i < 42 && valid)
            nvalid++;
         if (i == 42) begin
            check("post_reset_valid", valid, 1);
            check("post_reset_duty", duty_out, 3);
            check("post_reset_period", period_out, 10);
         end
      end
      check("post_reset_no_early_valid", nvalid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
